// File: rtl/ps2_rx_fifo_pkg.sv
// Shared definitions for the PS/2 receive path: frame states, frame-bit levels
// and default sizing for the receiver and its scan-code FIFO.
package ps2_rx_fifo_pkg;

    typedef enum logic [1:0] {
        PS2_IDLE,
        PS2_DATA,
        PS2_PARITY,
        PS2_STOP
    } ps2State_t;

    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;

    localparam int DEFAULT_FIFO_DEPTH     = 4;
    localparam int DEFAULT_FILTER_LEN     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_fifo.sv
// Generic show-ahead synchronous FIFO: the head entry is visible on popData
// whenever the FIFO is not empty, and a pop simply advances to the next entry.
module scan_code_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign doPop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPush  = push && (!full || doPop);
    assign popData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge Clock) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (doPush && !doPop) begin
                count <= count + (AW+1)'(1);
            end else if (doPop && !doPush) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises and filters the pins, deframes
// 11-bit frames, checks them and queues good scan codes in a show-ahead FIFO.
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2Clk,
    input  logic       iPS2Data,
    input  logic       iRead,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oParityError,
    output logic       oFrameError,
    output logic       oOverflow
);

    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    logic [1:0]     clkSync;
    logic [1:0]     dataSync;
    logic           filtClk;
    logic [FCW-1:0] filtCnt;
    logic           fall;
    logic           sampledData;

    ps2State_t      state, stateNext;
    logic [7:0]     shiftReg, shiftNext;
    logic [2:0]     bitCnt, bitCntNext;
    logic           parityBit, parityNext;
    logic [TW-1:0]  timeoutCnt, timeoutNext;
    logic           pushReq;
    logic           parityErrNext;
    logic           frameErrNext;

    logic           fifoFull;
    logic           fifoEmpty;

    assign sampledData = dataSync[1];

    // Idle PS/2 lines float high, so the synchronisers reset to 1 to avoid a spurious edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], iPS2Clk};
            dataSync <= {dataSync[0], iPS2Data};
        end
    end

    // The filtered clock follows the pin only after FILTER_LEN disagreeing samples in a row.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            filtClk <= 1'b1;
            filtCnt <= '0;
            fall    <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clkSync[1] != filtClk) begin
                if (filtCnt == FCW'(FILTER_LEN - 1)) begin
                    filtClk <= clkSync[1];
                    filtCnt <= '0;
                    fall    <= filtClk;
                end else begin
                    filtCnt <= filtCnt + FCW'(1);
                end
            end else begin
                filtCnt <= '0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= PS2_IDLE;
            shiftReg     <= '0;
            bitCnt       <= '0;
            parityBit    <= 1'b0;
            timeoutCnt   <= '0;
            oParityError <= 1'b0;
            oFrameError  <= 1'b0;
            oOverflow    <= 1'b0;
        end else begin
            state        <= stateNext;
            shiftReg     <= shiftNext;
            bitCnt       <= bitCntNext;
            parityBit    <= parityNext;
            timeoutCnt   <= timeoutNext;
            oParityError <= parityErrNext;
            oFrameError  <= frameErrNext;
            oOverflow    <= pushReq && fifoFull && !iRead;
        end
    end

    always_comb begin
        stateNext     = state;
        shiftNext     = shiftReg;
        bitCntNext    = bitCnt;
        parityNext    = parityBit;
        timeoutNext   = (state == PS2_IDLE || fall) ? '0 : timeoutCnt + TW'(1);
        pushReq       = 1'b0;
        parityErrNext = 1'b0;
        frameErrNext  = 1'b0;

        case (state)
            PS2_IDLE: begin
                if (fall) begin
                    if (sampledData == PS2_START_BIT) begin
                        stateNext  = PS2_DATA;
                        bitCntNext = '0;
                    end else begin
                        frameErrNext = 1'b1;
                    end
                end
            end
            PS2_DATA: begin
                if (fall) begin
                    shiftNext  = {sampledData, shiftReg[7:1]};
                    bitCntNext = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        stateNext = PS2_PARITY;
                    end
                end
            end
            PS2_PARITY: begin
                if (fall) begin
                    parityNext = sampledData;
                    stateNext  = PS2_STOP;
                end
            end
            PS2_STOP: begin
                // A bad stop bit takes precedence; parity is only judged on a well-framed byte.
                if (fall) begin
                    stateNext = PS2_IDLE;
                    if (sampledData != PS2_STOP_BIT) begin
                        frameErrNext = 1'b1;
                    end else if (!oddParityOk(shiftReg, parityBit)) begin
                        parityErrNext = 1'b1;
                    end else begin
                        pushReq = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = PS2_IDLE;
            end
        endcase

        if (state != PS2_IDLE && !fall && timeoutCnt == TW'(TIMEOUT_CYCLES - 1)) begin
            stateNext    = PS2_IDLE;
            timeoutNext  = '0;
            frameErrNext = 1'b1;
        end
    end

    scan_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) fifo (
        .Clock    (Clock),
        .Reset    (Reset),
        .push     (pushReq),
        .pushData (shiftReg),
        .pop      (iRead),
        .popData  (oData),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign oValid = !fifoEmpty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: drives PS/2 frames bit by bit and compares
// the FIFO outputs and error pulses against a queue-based model of received bytes.
module tb_ps2_rx_fifo;

    localparam int FL    = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 300;
    localparam int HP    = 20;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iPS2Clk;
    logic       iPS2Data;
    logic       iRead;
    logic [7:0] oData;
    logic       oValid;
    logic       oParityError;
    logic       oFrameError;
    logic       oOverflow;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model[$];
    bit         checkEn = 1'b0;
    int         actPar = 0, actFrm = 0, actOvf = 0;
    int         expPar = 0, expFrm = 0, expOvf = 0;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iPS2Clk      (iPS2Clk),
        .iPS2Data     (iPS2Data),
        .iRead        (iRead),
        .oData        (oData),
        .oValid       (oValid),
        .oParityError (oParityError),
        .oFrameError  (oFrameError),
        .oOverflow    (oOverflow)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Sampled just after each rising edge: count pulses, compare FIFO view against the model.
    always begin
        @(posedge Clock);
        #1;
        if (oParityError === 1'b1) actPar++;
        if (oFrameError === 1'b1) actFrm++;
        if (oOverflow === 1'b1) actOvf++;
        if (checkEn) begin
            checkOutput("oValid", {31'd0, oValid}, {31'd0, model.size() != 0});
            if (model.size() != 0) begin
                checkOutput("oData", {24'd0, oData}, {24'd0, model[0]});
            end
        end
    end

    // Outcome of a complete frame as seen from the outside of the receiver.
    task automatic modelFrame(input logic [7:0] data, input logic par, input logic stop);
        if (stop !== 1'b1) expFrm++;
        else if (^{data, par} == 1'b0) expPar++;
        else if (model.size() == DEPTH) expOvf++;
        else model.push_back(data);
    endtask

    // Sends one 11-bit frame. popAt>0 raises iRead for one cycle at that many
    // cycles after the stop-bit fall, expecting popExp at the head.
    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                                 input int popAt, input logic [7:0] popExp);
        logic [10:0] bits;
        bits = {stop, par, data, 1'b0};
        for (int b = 0; b < 11; b++) begin
            @(negedge Clock);
            iPS2Data = bits[b];
            repeat (HP) @(negedge Clock);
            iPS2Clk = 1'b0;
            if (b == 10) begin
                checkEn = 1'b0;
                for (int c = 1; c <= FL + 4; c++) begin
                    @(negedge Clock);
                    iRead = (c == popAt);
                    if (c == popAt) begin
                        checkOutput("popAtPush", {24'd0, oData}, {24'd0, popExp});
                        void'(model.pop_front());
                    end
                end
                iRead = 1'b0;
                modelFrame(data, par, stop);
                checkEn = 1'b1;
                repeat (HP - FL - 4) @(negedge Clock);
            end else begin
                repeat (HP) @(negedge Clock);
            end
            iPS2Clk = 1'b1;
        end
        @(negedge Clock);
        iPS2Data = 1'b1;
        repeat (HP) @(negedge Clock);
    endtask

    // Start bit plus nData data bits, then the lines are left idle-high.
    task automatic partialFrame(input int nData, input logic [7:0] data);
        logic [8:0] bits;
        bits = {data, 1'b0};
        for (int b = 0; b <= nData; b++) begin
            @(negedge Clock);
            iPS2Data = bits[b];
            repeat (HP) @(negedge Clock);
            iPS2Clk = 1'b0;
            repeat (HP) @(negedge Clock);
            iPS2Clk = 1'b1;
        end
        @(negedge Clock);
        iPS2Data = 1'b1;
    endtask

    task automatic popByte(input logic [7:0] expected);
        @(negedge Clock);
        checkOutput("popData", {24'd0, oData}, {24'd0, expected});
        iRead = 1'b1;
        if (model.size() != 0) void'(model.pop_front());
        @(negedge Clock);
        iRead = 1'b0;
    endtask

    task automatic checkErrors(input string tag);
        checkOutput({tag, "_parity"}, actPar, expPar);
        checkOutput({tag, "_frame"}, actFrm, expFrm);
        checkOutput({tag, "_overflow"}, actOvf, expOvf);
    endtask

    initial begin
        logic [7:0] b8;
        Reset    = 1'b1;
        iPS2Clk  = 1'b1;
        iPS2Data = 1'b1;
        iRead    = 1'b0;
        repeat (3) @(negedge Clock);
        checkOutput("rst_oValid", {31'd0, oValid}, 32'd0);
        checkOutput("rst_oData", {24'd0, oData}, 32'd0);
        checkOutput("rst_pulses", {29'd0, oParityError, oFrameError, oOverflow}, 32'd0);
        Reset = 1'b0;
        checkEn = 1'b1;
        repeat (10) @(negedge Clock);

        // Single good byte, then drain it
        applyStimulus(8'h1C, 1'b0, 1'b1, 0, 8'h00);
        checkOutput("t1_valid", {31'd0, oValid}, 32'd1);
        popByte(8'h1C);
        checkErrors("t1");

        // Bad parity, then bad stop with bad parity
        applyStimulus(8'h1C, 1'b1, 1'b1, 0, 8'h00);
        checkOutput("t2_parityCount", actPar, 32'd1);
        applyStimulus(8'h1C, 1'b1, 1'b0, 0, 8'h00);
        checkErrors("t2");

        // Two entries in order
        applyStimulus(8'hF0, 1'b1, 1'b1, 0, 8'h00);
        applyStimulus(8'h1C, 1'b0, 1'b1, 0, 8'h00);
        popByte(8'hF0);
        popByte(8'h1C);
        checkErrors("t3");

        // Overflow on the fifth byte
        for (int i = 1; i <= 5; i++) begin
            b8 = 8'(i);
            applyStimulus(b8, ~^b8, 1'b1, 0, 8'h00);
        end
        checkOutput("t4_ovfCount", actOvf, 32'd1);
        for (int i = 1; i <= 4; i++) popByte(8'(i));
        // Refill, then pop exactly on the push edge of a fifth byte (2 sync + FL filter + 1)
        for (int i = 8'h11; i <= 8'h14; i++) begin
            b8 = 8'(i);
            applyStimulus(b8, ~^b8, 1'b1, 0, 8'h00);
        end
        applyStimulus(8'h15, ~^8'h15, 1'b1, FL + 2, 8'h11);
        for (int i = 8'h12; i <= 8'h15; i++) popByte(8'(i));
        checkErrors("t4");

        // Timeout mid-frame, then recovery
        partialFrame(3, 8'h05);
        repeat (TO + 50) @(negedge Clock);
        expFrm++;
        checkErrors("t5_timeout");
        applyStimulus(8'h29, 1'b0, 1'b1, 0, 8'h00);
        popByte(8'h29);
        checkErrors("t5");

        // Short glitch on the clock pin must be filtered out
        @(negedge Clock);
        iPS2Clk = 1'b0;
        repeat (2) @(negedge Clock);
        iPS2Clk = 1'b1;
        repeat (20) @(negedge Clock);
        checkErrors("t6_glitch");

        // Asynchronous reset mid-frame with two bytes queued
        applyStimulus(8'hA5, 1'b1, 1'b1, 0, 8'h00);
        applyStimulus(8'h3C, 1'b1, 1'b1, 0, 8'h00);
        partialFrame(2, 8'h77);
        @(posedge Clock);
        #3;
        Reset = 1'b1;
        checkEn = 1'b0;
        model.delete();
        #1;
        checkOutput("arst_oValid", {31'd0, oValid}, 32'd0);
        checkOutput("arst_oData", {24'd0, oData}, 32'd0);
        checkOutput("arst_pulses", {29'd0, oParityError, oFrameError, oOverflow}, 32'd0);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        checkEn = 1'b1;
        repeat (10) @(negedge Clock);
        applyStimulus(8'h1C, 1'b0, 1'b1, 0, 8'h00);
        popByte(8'h1C);
        checkErrors("t6");

        repeat (5) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
